// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITERS = 32;

  localparam logic MD_SEL_MULT = 1'b0;
  localparam logic MD_SEL_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } md_state_t;

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement: val_o = neg_i ? -val_i : val_i (wrapping).
module md_cond_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) with HI/LO registers.
// Optional MD_UNSIGNED_EN adds is_unsigned for MULTU/DIVU semantics.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITERS = MD_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_write,
`ifdef MD_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(ITERS) + 1;

  md_state_t          state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               sel_q, sel_d;
  logic               div0_q, div0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [2*WIDTH-1:0] hilo_q, hilo_d;

  logic               op_unsigned;
  logic               in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;

`ifdef MD_UNSIGNED_EN
  assign op_unsigned = is_unsigned;
`else
  assign op_unsigned = 1'b0;
`endif

  assign in_sign_a = ~op_unsigned & op_a[WIDTH-1];
  assign in_sign_b = ~op_unsigned & op_b[WIDTH-1];

  md_cond_neg #(.W(WIDTH)) u_mag_a (.val_i(op_a), .neg_i(in_sign_a), .val_o(in_mag_a));
  md_cond_neg #(.W(WIDTH)) u_mag_b (.val_i(op_b), .neg_i(in_sign_b), .val_o(in_mag_b));

  md_cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .val_o(fix_prod)
  );
  md_cond_neg #(.W(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .val_o(fix_quo)
  );
  md_cond_neg #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_a_q), .val_o(fix_rem)
  );

  // acc holds {upper, multiplier} for MULT and {rem, quo} for DIV.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, mag_b_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - mag_b_q;

  always_comb begin
    state_d  = state_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sel_d    = sel_q;
    div0_d   = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    res_d    = res_q;
    hilo_d   = hilo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_sel == MD_SEL_DIV && op_b == '0) begin
            div0_d = 1'b1;
          end else begin
            mag_a_d  = in_mag_a;
            mag_b_d  = in_mag_b;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            sel_d    = md_sel;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        acc_d   = (sel_q == MD_SEL_DIV) ? {{WIDTH{1'b0}}, mag_a_q} : {{WIDTH{1'b0}}, mag_b_q};
        state_d = ITER;
      end
      ITER: begin
        if (sel_q == MD_SEL_MULT) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        res_d   = (sel_q == MD_SEL_MULT) ? fix_prod : {fix_rem, fix_quo};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commit only when not busy; a start in the same cycle still sees the old result.
    if (hilo_write && (state_q == IDLE || state_q == DONE)) hilo_d = res_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sel_q    <= MD_SEL_MULT;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      hilo_q   <= '0;
    end else begin
      state_q  <= state_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sel_q    <= sel_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      hilo_q   <= hilo_d;
    end
  end

  assign busy   = (state_q == LOAD) || (state_q == ITER) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign div0   = div0_q;
  assign hi_out = hilo_q[2*WIDTH-1:WIDTH];
  assign lo_out = hilo_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes model results, monitor pops on done/div0.
module tb_mult_div_unit;

  localparam int LAT  = 35;
  localparam int BUSY = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        md_sel = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hilo_write = 1'b0;
`ifdef MD_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  logic        busy, done, div0;
  logic [31:0] hi_out, lo_out;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .md_sel(md_sel),
    .op_a(op_a), .op_b(op_b), .hilo_write(hilo_write),
`ifdef MD_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy(busy), .done(done), .div0(div0), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_div0;
    bit          commit;
    int          t0;
    logic [63:0] res;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] res_m = '0;   // model of the internal result
  logic [63:0] hilo_m = '0;  // model of architectural HI:LO

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(bit sel, bit uns, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    longint sa, sb, qt, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sel) begin
      if (uns) r = {32'd0, a} * {32'd0, b};
      else     r = sa * sb;
    end else begin
      if (uns) r = {a % b, a / b};
      else begin
        qt = sa / sb;
        rm = sa % sb;
        r  = {rm[31:0], qt[31:0]};
      end
    end
    return r;
  endfunction

  // Monitor
  bit          pend = 1'b0;
  logic [63:0] pend_exp;
  int          bcnt = 0;

  always begin
    @(negedge clk);
    if (!reset) begin
      bcnt = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hilo_after_done", {hi_out, lo_out}, pend_exp);
        hilo_m = pend_exp;
        pend = 1'b0;
      end
      if (busy) bcnt++;
      if (div0) begin
        if (q.size() == 0) check("unexpected_div0", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("div0_kind", 64'(e.is_div0), 64'd1);
          check("div0_latency", 64'(cyc - e.t0), 64'd1);
          check("div0_busy_cycles", 64'(bcnt), 64'd0);
        end
        bcnt = 0;
      end
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("done_kind", 64'(e.is_div0), 64'd0);
          check("done_latency", 64'(cyc - e.t0), 64'(LAT));
          check("busy_cycles", 64'(bcnt), 64'(BUSY));
          res_m    = e.res;
          pend_exp = e.commit ? e.res : hilo_m;
          pend     = 1'b1;
        end
        bcnt = 0;
      end
    end
  end

  // Driver
  task automatic issue(input bit sel, input bit uns, input logic [31:0] a, input logic [31:0] b,
                       input bit hw_start, input bit commit, input bit inject);
    exp_t e;
    bit   is_d0;
    bit   seen;
    is_d0 = sel && (b == 32'd0);
    @(negedge clk);
    start = 1'b1; md_sel = sel; op_a = a; op_b = b; hilo_write = hw_start;
`ifdef MD_UNSIGNED_EN
    is_unsigned = uns;
`endif
    e.is_div0 = is_d0;
    e.commit  = commit;
    e.t0      = cyc;
    e.res     = is_d0 ? 64'd0 : model(sel, uns, a, b);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; hilo_write = 1'b0;
    if (hw_start) begin
      check("hilo_with_start", {hi_out, lo_out}, res_m);
      hilo_m = res_m;
    end
    if (is_d0) return;
    if (inject) begin
      repeat (4) @(negedge clk);
      start = 1'b1; md_sel = ~sel; op_a = $urandom; op_b = $urandom; hilo_write = 1'b1;
      @(negedge clk);
      start = 1'b0; hilo_write = 1'b0;
      check("hilo_hold_busy", {hi_out, lo_out}, hilo_m);
    end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    hilo_write = commit;
    @(negedge clk);
    hilo_write = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          s, u;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div0", 64'(div0), 64'd0);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(1'b0, 1'b0, 32'd7, -32'd3, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 1'b0, -32'd17, 32'd5, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 32'd12345, 32'd678, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Abort 0x80000000 * 0x80000000 at ITER counter 10.
    @(negedge clk);
    start = 1'b1; md_sel = 1'b0; op_a = 32'h8000_0000; op_b = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi_out, lo_out}, 64'd0);
    res_m = '0;
    hilo_m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

`ifdef MD_UNSIGNED_EN
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd7, 1'b0, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      u = 1'b0;
`ifdef MD_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`endif
      a = pick();
      b = pick();
      issue(s, u, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 7) == 0));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits downstream of the multicycle control unit:
  - Control raises start with md_sel (its MDCtrl) at the stateOP cycle, idles in its wait state, then pulses hilo_write (its HILOWrite) to commit.
  - div0 feeds the control's exception path; hi_out/lo_out feed the register-file DataSrc mux (MFHI/MFLO).

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH.
- ITERS, WIDTH, iteration cycles per operation.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- md_sel  input  1  0 = MULT, 1 = DIV
- op_a  input  WIDTH  rs value (multiplicand / dividend)
- op_b  input  WIDTH  rt value (multiplier / divisor)
- hilo_write  input  1  commit internal result to HI/LO
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse; result valid
- div0  output  1  one-cycle pulse; DIV requested with op_b == 0
- hi_out  output  WIDTH  architectural HI
- lo_out  output  WIDTH  architectural LO

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - busy, done, div0 = 0; hi_out, lo_out = 0.
  - Internal result and working registers = 0.
  - Applies mid-operation too: the operation is abandoned and no done pulse is issued.
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE:
  - start & md_sel & (op_b == 0): div0 = 1 for the next cycle; stay IDLE; busy stays 0; result unchanged.
  - Otherwise, start: latch |op_a| and |op_b| as magnitudes, latch sign_a/sign_b and md_sel; go to LOAD.
- LOAD (1 cycle): clear the accumulator / partial remainder, iteration counter = 0; busy = 1.
- ITER (ITERS cycles, counter 0..ITERS-1):
  - MULT: shift-add. If the multiplier LSB is set, add the multiplicand into the upper half; shift the 64-bit product right by 1.
  - DIV: restoring. Shift {rem, quo} left by 1. If rem >= divisor, subtract and set the quotient LSB.
  - Leave to FIX when counter == ITERS-1.
- FIX (1 cycle):
  - MULT: if sign_a ^ sign_b, negate the 64-bit product. Result hi:lo = product.
  - DIV: quotient negated if sign_a ^ sign_b; remainder negated if sign_a. lo = quotient, hi = remainder.
- DONE (1 cycle): done = 1, busy = 0; return to IDLE.
- Latency: start at cycle 0 → done at cycle ITERS+3 (35 for the default), within the control's 40-cycle wait.
- hilo_write:
  - In IDLE/DONE: hi_out/lo_out <= internal result on the next edge.
  - While busy: ignored; HI/LO hold.
  - hilo_write in the same cycle as start: commits the old result; the new operation proceeds.
- start while busy: ignored.
- Arithmetic edge cases, all wrapping and no flags:
  - INT_MIN / -1 → lo = 0x80000000, hi = 0.
  - INT_MIN * INT_MIN → hi = 0x40000000, lo = 0.
- Magnitude of INT_MIN is held as an unsigned 32-bit value 0x80000000 (no overflow).

Optional Feature:
- Macro: MD_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When 1, sign extraction and the FIX negations are skipped (MULTU/DIVU semantics).
  - div0 rules are unchanged.
- Undefined: port absent; all operations are signed.

Decomposition:
- Package md_pkg:
  - md_state_t enum (IDLE, LOAD, ITER, FIX, DONE).
  - MD_WIDTH = 32, MD_ITERS = 32.
  - MD_SEL_MULT = 1'b0, MD_SEL_DIV = 1'b1.
- Sub-module md_cond_neg: parameterised-width conditional two's-complement, used for operand magnitudes and FIX.

Test Plan:
- MULT 7 * -3, then hilo_write after done → done at cycle 35; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV -17 / 5 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFE (-2); busy high for 34 cycles.
- DIV 100 / 0 → div0 pulse the cycle after start; busy never rises; HI/LO and result unchanged.
- Second start during busy, plus hilo_write during busy → both ignored; first result intact, HI/LO hold the old values until a post-done hilo_write.
- reset dropped at ITER cycle 10 of 0x80000000 * 0x80000000 → all outputs 0 immediately, no done pulse; rerun → hi = 0x40000000, lo = 0.
- With MD_UNSIGNED_EN, is_unsigned = 1, MULTU 0xFFFFFFFF * 2 → hi = 0x00000001, lo = 0xFFFFFFFE.
